// File: rtl/sqrt_operand_fifo_pkg.sv
// Shared fp32 field layout and classification result type for the sqrt operand path.
package sqrt_operand_fifo_pkg;

    localparam int FP32_W        = 32;
    localparam int FP32_SIGN_BIT = 31;
    localparam int FP32_EXP_MSB  = 30;
    localparam int FP32_EXP_LSB  = 23;
    localparam int FP32_MANT_MSB = 22;
    localparam int FP32_MANT_LSB = 0;
    localparam logic [7:0] FP32_EXP_ALL1 = 8'hFF;

    typedef struct packed {
        logic is_zero;
        logic is_nan;
        logic is_neg_drop;
    } fp32_class_t;

endpackage

// File: rtl/sqrt_operand_fifo_fp32_classify.sv
// Combinational fp32 classifier: zero, NaN, and "negative with no defined sqrt".
module fp32_classify
    import sqrt_operand_fifo_pkg::*;
(
    input  logic [FP32_W-1:0] operand,
    output fp32_class_t       cls
);

    logic                                 sign;
    logic [FP32_EXP_MSB-FP32_EXP_LSB:0]   exp_f;
    logic [FP32_MANT_MSB-FP32_MANT_LSB:0] mant_f;
    logic                                 exp_zero;
    logic                                 exp_ones;
    logic                                 mant_zero;

    assign sign      = operand[FP32_SIGN_BIT];
    assign exp_f     = operand[FP32_EXP_MSB:FP32_EXP_LSB];
    assign mant_f    = operand[FP32_MANT_MSB:FP32_MANT_LSB];
    assign exp_zero  = (exp_f == '0);
    assign exp_ones  = (exp_f == FP32_EXP_ALL1);
    assign mant_zero = (mant_f == '0);

    // -0 and -NaN have well-defined sqrt results, everything else negative does not
    always_comb begin
        cls             = '0;
        cls.is_zero     = exp_zero && mant_zero;
        cls.is_nan      = exp_ones && !mant_zero;
        cls.is_neg_drop = sign && !cls.is_zero && !cls.is_nan;
    end

endmodule

// File: rtl/sqrt_operand_fifo.sv
// Operand FIFO in front of the fp32 sqrt core; optionally filters negative operands.
module sqrt_operand_fifo
    import sqrt_operand_fifo_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 8,
    parameter int AW       = 3,
    parameter bit DROP_NEG = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] input_a,
    input  logic             input_a_stb,
    output logic             input_a_ack,
    output logic [WIDTH-1:0] output_z,
    output logic             output_z_stb,
    input  logic             output_z_ack,
    output logic [AW:0]      level,
    output logic             full,
    output logic             empty,
    output logic [15:0]      neg_drop_count
);

    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    fp32_class_t      cls;
    logic             accept;
    logic             drop;
    logic             push;
    logic             pop;
    logic             unused_cls;

    fp32_classify u_classify (
        .operand (input_a[FP32_W-1:0]),
        .cls     (cls)
    );

    assign unused_cls = cls.is_zero ^ cls.is_nan;

    assign full         = (level == LVL_FULL);
    assign empty        = (level == '0);
    assign input_a_ack  = ~full;
    assign output_z_stb = ~empty;
    assign output_z     = mem[rd_ptr];

    // A dropped operand still consumes a handshake, so it also waits on ~full
    assign accept = input_a_stb && input_a_ack;
    assign drop   = accept && DROP_NEG && cls.is_neg_drop;
    assign push   = accept && !drop;
    assign pop    = output_z_stb && output_z_ack;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= input_a;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            neg_drop_count <= '0;
        else if (drop && neg_drop_count != 16'hFFFF)
            neg_drop_count <= neg_drop_count + 16'd1;
    end

endmodule

// File: tb/tb_sqrt_operand_fifo.sv
// Directed bench for sqrt_operand_fifo: queue model checked every cycle plus literal pins.
module tb_sqrt_operand_fifo;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] input_a = '0;
    logic        input_a_stb = 1'b0;
    logic        output_z_ack = 1'b0;

    logic        input_a_ack;
    logic [31:0] output_z;
    logic        output_z_stb;
    logic [3:0]  level;
    logic        full;
    logic        empty;
    logic [15:0] neg_drop_count;

    logic        n_input_a_ack;
    logic [31:0] n_output_z;
    logic        n_output_z_stb;
    logic [3:0]  n_level;
    logic        n_full;
    logic        n_empty;
    logic [15:0] n_neg_drop_count;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sqrt_operand_fifo #(.WIDTH(32), .DEPTH(DEPTH), .AW(3), .DROP_NEG(1'b1)) dut (
        .clk(clk), .rst(rst),
        .input_a(input_a), .input_a_stb(input_a_stb), .input_a_ack(input_a_ack),
        .output_z(output_z), .output_z_stb(output_z_stb), .output_z_ack(output_z_ack),
        .level(level), .full(full), .empty(empty), .neg_drop_count(neg_drop_count)
    );

    sqrt_operand_fifo #(.WIDTH(32), .DEPTH(DEPTH), .AW(3), .DROP_NEG(1'b0)) dut_nodrop (
        .clk(clk), .rst(rst),
        .input_a(input_a), .input_a_stb(input_a_stb), .input_a_ack(n_input_a_ack),
        .output_z(n_output_z), .output_z_stb(n_output_z_stb), .output_z_ack(output_z_ack),
        .level(n_level), .full(n_full), .empty(n_empty), .neg_drop_count(n_neg_drop_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: an in-order queue plus a saturating drop counter
    logic [31:0] mq[$];
    int          m_drops = 0;
    bit          m_pop, m_acc, m_neg;

    function automatic bit undefined_sqrt(input logic [31:0] v);
        bit is_zero = (v[30:0] == 31'd0);
        bit is_nan  = (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
        return v[31] && !is_zero && !is_nan;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_drops = 0;
        end else begin
            m_pop = (mq.size() > 0) && output_z_ack;
            m_acc = input_a_stb && (mq.size() < DEPTH);
            m_neg = undefined_sqrt(input_a);
            if (m_pop)
                void'(mq.pop_front());
            if (m_acc) begin
                if (m_neg) begin
                    if (m_drops < 16'hFFFF)
                        m_drops++;
                end else begin
                    mq.push_back(input_a);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("level",        32'(level),        32'(mq.size()));
            chk("output_z_stb", 32'(output_z_stb), 32'(mq.size() != 0));
            chk("empty",        32'(empty),        32'(mq.size() == 0));
            chk("full",         32'(full),         32'(mq.size() == DEPTH));
            chk("input_a_ack",  32'(input_a_ack),  32'(mq.size() != DEPTH));
            chk("drop_count",   32'(neg_drop_count), 32'(m_drops));
            if (mq.size() != 0)
                chk("output_z", output_z, mq[0]);
        end
    end

    // Holds stb/data until ack is seen between edges; caller is at a negedge
    task automatic push(input logic [31:0] w);
        bit done = 1'b0;
        input_a = w;
        input_a_stb = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            done = input_a_ack;
            @(negedge clk);
        end
        input_a_stb = 1'b0;
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL push_timeout: got no ack, expected ack for %h", w);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
    endtask

    logic [31:0] fill_vals [9] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                                   32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
                                   32'h41100000};
    logic [31:0] filt_vals [4] = '{32'hC0000000, 32'h80000000, 32'hFFC00000, 32'hFF800000};
    logic [31:0] drained[$];
    bit          took;

    initial begin
        // Reset
        #1000;
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("rst_stb",   32'(output_z_stb), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_drops", 32'(neg_drop_count), 32'd0);
        chk("rst_ack",   32'(input_a_ack), 32'd1);

        // Single operand
        push(32'h41C80000);
        chk("single_stb",   32'(output_z_stb), 32'd1);
        chk("single_z",     output_z, 32'h41C80000);
        chk("single_level", 32'(level), 32'd1);
        output_z_ack = 1'b1;
        @(negedge clk);
        output_z_ack = 1'b0;
        chk("single_empty", 32'(empty), 32'd1);

        // Fill, hold a 9th, then drain
        for (int i = 0; i < 8; i++)
            push(fill_vals[i]);
        input_a = fill_vals[8];
        input_a_stb = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("fill_full",  32'(full), 32'd1);
        chk("fill_ack",   32'(input_a_ack), 32'd0);
        chk("fill_level", 32'(level), 32'd8);
        output_z_ack = 1'b1;
        took = 1'b0;
        for (int i = 0; i < 14; i++) begin
            if (output_z_stb)
                drained.push_back(output_z);
            took = input_a_stb && input_a_ack;
            @(negedge clk);
            if (took)
                input_a_stb = 1'b0;
        end
        output_z_ack = 1'b0;
        chk("drain_count", 32'(drained.size()), 32'd9);
        for (int i = 0; i < 9 && i < drained.size(); i++)
            chk($sformatf("drain_%0d", i), drained[i], fill_vals[i]);

        // Negative-operand filter, both DROP_NEG settings
        do_reset();
        for (int i = 0; i < 4; i++)
            push(filt_vals[i]);
        chk("filt_drops",    32'(neg_drop_count), 32'd2);
        chk("filt_level",    32'(level), 32'd2);
        chk("filt_head0",    output_z, 32'h80000000);
        chk("nodrop_level",  32'(n_level), 32'd4);
        chk("nodrop_drops",  32'(n_neg_drop_count), 32'd0);
        chk("nodrop_head0",  n_output_z, 32'hC0000000);
        output_z_ack = 1'b1;
        @(negedge clk);
        output_z_ack = 1'b0;
        chk("filt_head1",    output_z, 32'hFFC00000);
        output_z_ack = 1'b1;
        @(negedge clk);
        output_z_ack = 1'b0;

        // Simultaneous push/pop at level 1
        do_reset();
        push(32'h40800000);
        input_a = 32'h41100000;
        input_a_stb = 1'b1;
        output_z_ack = 1'b1;
        @(negedge clk);
        input_a_stb = 1'b0;
        output_z_ack = 1'b0;
        chk("simul1_level", 32'(level), 32'd1);
        chk("simul1_head",  output_z, 32'h41100000);

        // Simultaneous at full: pop only, push lands next edge
        for (int i = 0; i < 7; i++)
            push(fill_vals[i]);
        chk("simulf_full", 32'(full), 32'd1);
        input_a = 32'h41200000;
        input_a_stb = 1'b1;
        output_z_ack = 1'b1;
        @(negedge clk);
        output_z_ack = 1'b0;
        chk("simulf_level7", 32'(level), 32'd7);
        chk("simulf_ack",    32'(input_a_ack), 32'd1);
        @(negedge clk);
        input_a_stb = 1'b0;
        chk("simulf_level8", 32'(level), 32'd8);
        chk("simulf_head",   output_z, 32'h3F800000);

        // Async reset between edges at level 5
        do_reset();
        for (int i = 0; i < 5; i++)
            push(fill_vals[i]);
        chk("arst_pre_level", 32'(level), 32'd5);
        #2 rst = 1'b1;
        #1;
        chk("arst_stb",   32'(output_z_stb), 32'd0);
        chk("arst_level", 32'(level), 32'd0);
        chk("arst_empty", 32'(empty), 32'd1);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);

        // Mixed traffic with random backpressure, including negative operands
        took = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!input_a_stb || took) begin
                input_a_stb = ($urandom_range(0, 3) != 0);
                input_a = $urandom();
            end
            took = input_a_stb && input_a_ack;
            output_z_ack = ($urandom_range(0, 2) == 0);
            @(negedge clk);
        end
        input_a_stb = 1'b0;
        output_z_ack = 1'b1;
        repeat (DEPTH + 2) @(negedge clk);
        chk("final_empty", 32'(empty), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
